fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage. Owns the PC and drives the address of the synchronous-read instruction memory (1-cycle latency).
//   Pairs each returned word with its PC and a valid bit for the IF/ID register. Supports stall (replay), redirect
//   (branch/jump target, kills wrong path) and halt at a programmed end address.
// PARAMETERS
//   DATA_WIDTH  32   instruction word width
//   ADDR_WIDTH  10   word address width (memory depth 1<<ADDR_WIDTH)
//   RESET_ADDR  0    first word address fetched after reset
//   END_ADDR    26   last word address fetched; fetch halts after issuing it
// PORTS
//   clk            in   1           clock, all state updates on posedge
//   rst            in   1           asynchronous, active-high reset
//   stall          in   1           downstream cannot accept; hold PC and current output
//   redirect       in   1           load redirect_addr as next fetch address; priority over stall
//   redirect_addr  in   ADDR_WIDTH target word address
//   imem_addr      out  ADDR_WIDTH address to instruction memory (sampled by memory on posedge)
//   imem_data      in   DATA_WIDTH registered read data from instruction memory
//   if_instr       out  DATA_WIDTH instruction to IF/ID (= imem_data, meaningful only when if_valid)
//   if_pc          out  ADDR_WIDTH word address of if_instr
//   if_valid       out  1          if_instr/if_pc hold a live instruction this cycle
//   halted         out  1          fetch stopped after END_ADDR
// BEHAVIOUR
//   State: pc (next address to issue), req_pc (address in flight), req_valid, FSM {FS_RUN, FS_HALT}.
//   Reset (async): pc=RESET_ADDR, req_pc=0, req_valid=0, FSM=FS_RUN, halted=0 -> if_valid=0, if_pc=0.
//   imem_addr (comb): redirect ? redirect_addr : stall ? req_pc : pc. FS_HALT without redirect: pc (don't-care).
//   Outputs: if_instr=imem_data; if_pc=req_pc; if_valid=req_valid & ~redirect (wrong-path word killed same cycle).
//   Latency: address issued in cycle t appears on if_instr in cycle t+1. First if_valid=1 in the first cycle after
//     the first posedge following rst deassert, with if_pc=RESET_ADDR.
//   FS_RUN, no stall/redirect: req_pc<=pc, req_valid<=1, pc<=pc+1 (mod 2^ADDR_WIDTH, 1023+1 wraps to 0).
//     If pc==END_ADDR: issue it as above, then FSM<=FS_HALT.
//   Stall (no redirect): pc, req_pc, req_valid, FSM hold; memory re-reads req_pc, so if_instr stays stable.
//   Redirect (any state, overrides stall): req_pc<=redirect_addr, req_valid<=1, pc<=redirect_addr+1,
//     FSM<=FS_RUN, or FS_HALT if redirect_addr==END_ADDR. No bubble beyond the killed word.
//   FS_HALT: halted=1. Last word drains: req_valid<=0 on the first non-stalled edge; req_valid holds while stall=1.
//     Only redirect or rst leaves FS_HALT.
//   rst mid-stall or mid-redirect: reset wins immediately; the in-flight word is discarded (if_valid=0).
//   No combinational path from imem_data to any control signal.
// STRUCTURE
//   Shared header mips_defs.vh: DATA_WIDTH/ADDR_WIDTH defaults, FS_RUN/FS_HALT localparam encodings, RESET_ADDR.
//   No sub-module; single always block for state plus continuous assigns.
//   Instantiated beside instructionmemory in the CPU top: imem_addr->address, dataOut->imem_data.
// TESTING (bench instantiates fetch_unit + instructionmemory with the standard program, END_ADDR=26)
//   1 Reset release, no stall -> if_valid rises 1 cycle later; if_pc 0,1,2,3 on consecutive cycles;
//     if_instr[31:26]=6'b000101 for pc 0-3, 6'b000100 at pc 4.
//   2 stall=1 for 3 cycles while if_pc=5 -> if_pc=5, if_instr=mem[5] stable for 4 cycles; then if_pc=6, no skip/dup.
//   3 redirect=1, redirect_addr=14 while if_pc=7 -> if_valid=0 that cycle; next cycle if_pc=14, then 15.
//   4 Run to end -> if_pc=26 valid for one cycle, then if_valid=0 and halted=1 indefinitely; redirect to 8 resumes at pc 8.
//   5 stall and redirect(20) asserted together -> redirect wins: next if_pc=20. Redirect to 1023 -> next pc wraps to 0.
//   6 rst pulsed asynchronously (mid-cycle) during stall at if_pc=10 -> if_valid=0 immediately; refetch from pc 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//
// Contents:
//   fetch_state_e       fetch FSM encoding (FS_RUN / FS_HALT)
//   DEF_DATA_WIDTH      default instruction word width
//   DEF_ADDR_WIDTH      default word-address width
//   DEF_RESET_ADDR      default first word address after reset
//   DEF_END_ADDR        default last word address before halting
package fetch_unit_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_RESET_ADDR = 0;
  localparam int DEF_END_ADDR   = 26;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
//
// Owns the program counter and drives the address of a synchronous-read
// instruction memory (one cycle of read latency). Each returned word is
// paired with the address it was read from and a valid bit for the IF/ID
// register. Supports stall (replay of the word in flight), redirect
// (branch/jump target, kills the wrong-path word) and halting once the
// programmed end address has been issued.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   rst            in   asynchronous, active-high reset
//   stall          in   downstream cannot accept; hold PC and current output
//   redirect       in   load redirect_addr as next fetch address; beats stall
//   redirect_addr  in   target word address
//   imem_addr      out  address to instruction memory (sampled on posedge)
//   imem_data      in   registered read data from instruction memory
//   if_instr       out  instruction to IF/ID (meaningful only when if_valid)
//   if_pc          out  word address of if_instr
//   if_valid       out  if_instr/if_pc hold a live instruction this cycle
//   halted         out  fetch stopped after END_ADDR
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESET_ADDR = DEF_RESET_ADDR,
  parameter int END_ADDR   = DEF_END_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_valid,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_PC   = ADDR_WIDTH'(END_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  // Sequential successor; wraps naturally at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_ONE;
  endfunction

  // pc: next address to issue. req_pc/req_valid: address currently in
  // flight in the memory, i.e. the word presented on imem_data this cycle.
  logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q,    req_pc_d;
  logic                  req_valid_q, req_valid_d;
  fetch_state_e          state_q,     state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      state_q     <= FS_RUN;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      state_q     <= state_d;
    end
  end

  // Next-state logic. Only control inputs are consulted; imem_data never
  // feeds any decision, so there is no path from memory data to control.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    state_d     = state_q;

    if (redirect) begin
      // Target is issued this cycle, so the pipeline continues without a
      // bubble; the only lost slot is the killed wrong-path word.
      req_pc_d    = redirect_addr;
      req_valid_d = 1'b1;
      pc_d        = next_addr(redirect_addr);
      state_d     = (redirect_addr == END_PC) ? FS_HALT : FS_RUN;
    end else if (stall) begin
      // Hold everything; the memory re-reads req_pc so imem_data is stable.
      pc_d        = pc_q;
    end else begin
      unique case (state_q)
        FS_RUN: begin
          req_pc_d    = pc_q;
          req_valid_d = 1'b1;
          pc_d        = next_addr(pc_q);
          if (pc_q == END_PC) begin
            state_d = FS_HALT;
          end
        end
        FS_HALT: begin
          // The last issued word has now been accepted; nothing follows it.
          req_valid_d = 1'b0;
        end
        default: begin
          state_d = FS_RUN;
        end
      endcase
    end
  end

  // During a stall the in-flight address is replayed so the word on
  // imem_data next cycle is the same one being held downstream.
  always_comb begin
    if (redirect) begin
      imem_addr = redirect_addr;
    end else if (stall) begin
      imem_addr = req_pc_q;
    end else begin
      imem_addr = pc_q;
    end
  end

  assign if_instr = imem_data;
  assign if_pc    = req_pc_q;
  // A redirect means the word currently in flight is on the wrong path.
  assign if_valid = req_valid_q & ~redirect;
  assign halted   = (state_q == FS_HALT);

endmodule : fetch_unit
